// File: rtl/uart_pkg.sv
// Shared encodings for the oversampling UART receiver: parity modes,
// receiver FSM states and the default oversampling rate.
package uart_pkg;

  localparam int OS_RATE_DEFAULT = 16;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level
// so a reset never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority-of-3 bit decisions around mid-bit,
// optional parity, one/two stop bits, single-word holding register.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int OS_RATE   = OS_RATE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 os_tick,
  input  logic                 rx,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy,
  output rx_state_e            dbg_state
);

  localparam int TW = $clog2(OS_RATE);
  localparam logic [TW-1:0] T_S0   = TW'(OS_RATE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OS_RATE / 2);
  localparam logic [TW-1:0] T_S2   = TW'(OS_RATE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OS_RATE - 1);
  localparam logic [3:0]    B_LAST = 4'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state, state_n;
  logic [TW-1:0]        tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           samp;
  logic                 par_en, par_odd, two_q, stop_idx;
  logic                 par_bit, perr_q, ferr_q, brk_q;
  logic                 decide, bit_end, maj, last_stop;
  logic                 brk_now, ferr_now, complete;

  uart_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  assign decide    = os_tick && (tick_cnt == T_S2);
  assign bit_end   = os_tick && (tick_cnt == T_LAST);
  // Third sample is the live synchronized value on the deciding tick.
  assign maj       = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign last_stop = !two_q || stop_idx;
  assign ferr_now  = ferr_q | !maj;
  assign brk_now   = stop_idx ? brk_q
                              : ((shreg == '0) && !(par_en && par_bit) && !maj);

  always_comb begin
    state_n  = state;
    complete = 1'b0;
    case (state)
      IDLE:      if (os_tick && !rx_s) state_n = START;
      START: begin
        if (decide && maj)  state_n = IDLE;
        else if (bit_end)   state_n = DATA;
      end
      DATA:      if (bit_end && (bit_cnt == B_LAST)) state_n = par_en ? PARITY : STOP;
      PARITY:    if (bit_end) state_n = STOP;
      STOP: begin
        if (decide && last_stop) begin
          complete = 1'b1;
          state_n  = ferr_now ? WAIT_IDLE : IDLE;
        end
      end
      WAIT_IDLE: if (os_tick && rx_s) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      samp     <= 2'b11;
      par_en   <= 1'b0;
      par_odd  <= 1'b0;
      two_q    <= 1'b0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
    end else if (state == IDLE) begin
      if (os_tick && !rx_s) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
        stop_idx <= 1'b0;
        par_bit  <= 1'b0;
        perr_q   <= 1'b0;
        ferr_q   <= 1'b0;
        brk_q    <= 1'b0;
        par_en   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
        par_odd  <= (parity_mode == PAR_ODD);
        two_q    <= two_stop;
      end
    end else if (os_tick) begin
      tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);
      if (tick_cnt == T_S0) samp[0] <= rx_s;
      if (tick_cnt == T_S1) samp[1] <= rx_s;
      if (decide) begin
        case (state)
          DATA:   shreg <= {maj, shreg[DATA_BITS-1:1]};
          PARITY: begin
            par_bit <= maj;
            perr_q  <= par_odd ? ~(^shreg ^ maj) : (^shreg ^ maj);
          end
          STOP: begin
            if (!maj)     ferr_q <= 1'b1;
            if (!stop_idx) brk_q <= brk_now;
          end
          default: ;
        endcase
      end
      if (bit_end && (state == DATA)) bit_cnt  <= bit_cnt + 4'd1;
      if (bit_end && (state == STOP)) stop_idx <= 1'b1;
    end
  end

  // Handshake: a word is held while rx_valid is high and is consumed on any
  // clk edge where rx_valid && rx_ready; a frame completing in that same
  // cycle replaces it, otherwise a completion into a full register is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      break_det <= 1'b0;
      if (complete) begin
        break_det <= brk_now;
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= perr_q;
          frame_err  <= ferr_now;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: directed scenarios plus randomized frames, with a
// frame-level reference model feeding an expected queue drained by a monitor.
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int W = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       os_tick;
  logic       rx;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       parity_err, frame_err, overrun, break_det, busy;
  rx_state_e  dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_ovr    = 0;
  int n_brk    = 0;
  int exp_ovr  = 0;
  int exp_brk  = 0;
  bit auto_ready = 1'b0;

  uart_rx_os #(.DATA_BITS(8), .OS_RATE(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .os_tick     (os_tick),
    .rx          (rx),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .break_det   (break_det),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // clock / reset / oversampling strobe
  always #5 clk = ~clk;

  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      os_tick = 1'b1;
      @(negedge clk);
      os_tick = 1'b0;
    end
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (auto_ready) rx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", rx_data);
        end else begin
          check("word{data,perr,ferr}", {22'd0, rx_data, parity_err, frame_err},
                {22'd0, exp_q.pop_front()});
        end
      end
      if (overrun)   n_ovr++;
      if (break_det) n_brk++;
    end
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!os_tick) @(posedge clk);
    end
    #2;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    wait_ticks(n);
  endtask

  // Reference model works at frame level: what the line carries decides the word and flags.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                            input logic bad_par, input logic [1:0] bad_stop,
                            input int gap, input logic drop);
    logic pbit, has_par, x, perr, ferr, brk;
    has_par = (pm == 2'b01) || (pm == 2'b10);
    pbit    = (^d) ^ (pm == 2'b10) ^ bad_par;
    x       = (^d) ^ pbit;
    perr    = (pm == 2'b01) ? x : (pm == 2'b10) ? !x : 1'b0;
    ferr    = bad_stop[0] | (ts & bad_stop[1]);
    brk     = (d == 8'h00) && (!has_par || !pbit) && bad_stop[0];
    if (drop) exp_ovr++;
    else      exp_q.push_back({d, perr, ferr});
    if (brk)  exp_brk++;
    parity_mode = pm;
    two_stop    = ts;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
    if (has_par) drive_bit(pbit, 16);
    drive_bit(!bad_stop[0], 16);
    if (ts) drive_bit(!bad_stop[1], 16);
    drive_bit(1'b1, gap * 16);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rx_valid) break;
    end
    check("drain_queue", exp_q.size(), 0);
  endtask

  task automatic ready_in_completion();
    rx_state_e st_prev;
    int cnt;
    bit found;
    st_prev = dbg_state;
    cnt     = 0;
    found   = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(posedge clk);
      #1;
      if (os_tick && st_prev == STOP) cnt++;
      st_prev = dbg_state;
      if (cnt == 9) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL stop_tick_search: got %0d ticks expected 9", cnt);
    end else begin
      repeat (3) @(posedge clk);
      #2 rx_ready = 1'b1;
      @(posedge clk);
      #2 rx_ready = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] d, pd;
    logic [1:0] pm, bs;
    logic ts, bp;
    reset_n = 1'b0; rx = 1'b1; parity_mode = 2'b00; two_stop = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_parity_err", parity_err, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_break_det", break_det, 0);
    check("reset_busy", busy, 0);
    reset_n = 1'b1;
    auto_ready = 1'b1;
    wait_ticks(20);

    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 2'b00, 1, 1'b0);
    wait_drain();
    send_frame(8'h03, 2'b01, 1'b0, 1'b1, 2'b00, 1, 1'b0);
    wait_drain();

    drive_bit(1'b0, 4);
    #1 check("glitch_busy_high", busy, 1);
    drive_bit(1'b1, 16);
    #1 check("glitch_busy_low", busy, 0);
    wait_drain();

    // overrun, then acceptance in the completion cycle
    auto_ready = 1'b0;
    #3 rx_ready = 1'b0;
    send_frame(8'h11, 2'b00, 1'b0, 1'b0, 2'b00, 0, 1'b0);
    send_frame(8'h22, 2'b00, 1'b0, 1'b0, 2'b00, 1, 1'b1);
    #1;
    check("overrun_count", n_ovr, exp_ovr);
    check("held_word_after_drop", rx_data, 8'h11);
    check("held_valid_after_drop", rx_valid, 1);
    fork
      send_frame(8'h22, 2'b00, 1'b0, 1'b0, 2'b00, 1, 1'b0);
      ready_in_completion();
    join
    #1;
    check("no_overrun_on_accept", n_ovr, exp_ovr);
    auto_ready = 1'b1;
    wait_drain();

    // break: line low for two frame times
    exp_q.push_back({8'h00, 1'b0, 1'b1});
    exp_brk++;
    parity_mode = 2'b00; two_stop = 1'b0;
    drive_bit(1'b0, 320);
    #1 check("break_busy_held", busy, 1);
    check("break_count", n_brk, exp_brk);
    drive_bit(1'b1, 16);
    #1 check("break_busy_release", busy, 0);
    wait_drain();

    // reset in the middle of data bit 4
    pd = 8'h5A;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(pd[i], 16);
    drive_bit(pd[4], 8);
    reset_n = 1'b0;
    #1 check("midreset_busy", busy, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(16);
    #1 check("postreset_valid", rx_valid, 0);
    send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 2'b00, 1, 1'b0);
    wait_drain();

    for (int n = 0; n < 24; n++) begin
      d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      pm = 2'($urandom_range(0, 3));
      ts = 1'($urandom_range(0, 1));
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_frame(d, pm, ts, bp, bs, (bs != 2'b00) ? 1 : $urandom_range(0, 2), 1'b0);
    end
    drive_bit(1'b1, 16);
    wait_drain();
    check("final_overrun_count", n_ovr, exp_ovr);
    check("final_break_count", n_brk, exp_brk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
